lsu: RTL

- Load/store unit sitting between the execute stage and the data cache.
- Accepts one memory op at a time and formats it into a word-aligned data-cache request with byte enables and replicated store data.
- Holds that request stable until the cache reports a hit, then extracts, aligns and sign/zero-extends load data into a registered response.
- Also sequences FENCE ops into a data-cache flush handshake. Single outstanding op, no pipelining across ops.

---
 rtl/lsu_pkg.sv | 21 ++
 rtl/lsu_align.sv | 37 +++
 rtl/lsu.sv | 105 ++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared op kinds, funct3 encodings and FSM states for the load/store unit
package lsu_pkg;
  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    STORE   = 2'd1,
    FENCE   = 2'd2,
    ILLEGAL = 2'd3
  } lsu_kind_t;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [2:0] {
    S_IDLE,
    S_MEM,
    S_FLUSH_REQ,
    S_FLUSH_WAIT,
    S_RESP
  } lsu_state_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: legality/alignment check, store formatting and load extraction
module lsu_align
  import lsu_pkg::*;
(
  input  lsu_kind_t   kind_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic        err_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);
  logic        f3_ok;
  logic        mis;
  logic [31:0] w;
  always_comb begin
    f3_ok   = kind_i == LOAD  ? funct3_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU} :
              kind_i == STORE ? funct3_i inside {F3_B, F3_H, F3_W} :
              kind_i == FENCE;
    // Halfword encodings share funct3[1:0]=01, word is 10; fences carry no size
    mis     = (kind_i == LOAD || kind_i == STORE) &&
              ((funct3_i[1:0] == 2'b01 && addr_i[0]) || (funct3_i[1:0] == 2'b10 && addr_i != 2'b00));
    err_o   = !f3_ok || mis;
    be_o    = kind_i != STORE   ? 4'b0000 :
              funct3_i == F3_B  ? 4'b0001 << addr_i :
              funct3_i == F3_H  ? 4'b0011 << addr_i : 4'b1111;
    wdata_o = funct3_i == F3_B ? {4{wdata_i[7:0]}} :
              funct3_i == F3_H ? {2{wdata_i[15:0]}} : wdata_i;
    w       = rdata_i >> {addr_i, 3'b000};
    rdata_o = funct3_i == F3_B  ? {{24{w[7]}}, w[7:0]} :
              funct3_i == F3_H  ? {{16{w[15]}}, w[15:0]} :
              funct3_i == F3_BU ? {24'd0, w[7:0]} :
              funct3_i == F3_HU ? {16'd0, w[15:0]} : w;
  end
endmodule

// File: rtl/lsu.sv
// lsu: load/store unit turning execute-stage ops into data-cache requests and FENCE flushes
module lsu
  import lsu_pkg::*;
#(
  parameter bit FENCE_FLUSH = 1'b1,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_kind,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [4:0]            req_rd,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [4:0]            resp_rd,
  output logic [31:0]           resp_data,
  output logic                  dc_valid,
  output logic [ADDR_WIDTH-1:0] dc_addr,
  output logic [31:0]           dc_wdata,
  output logic [3:0]            dc_byte_enable,
  input  logic                  dc_ready,
  input  logic [31:0]           dc_rdata,
  output logic                  dc_flash,
  input  logic                  dc_flash_done
);
  lsu_state_t            state_q;
  lsu_kind_t             kind_q;
  logic [2:0]            f3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           data_q;
  logic [4:0]            rd_q;
  logic                  err_q;
  logic                  idle;
  logic                  err;
  lsu_kind_t             a_kind;
  logic [2:0]            a_f3;
  logic [1:0]            a_lo;
  logic [31:0]           fmt_wd;
  logic [31:0]           ld;
  logic [3:0]            be;
  // The checker sees the live request while idle and the held op otherwise
  assign idle   = state_q == S_IDLE;
  assign a_kind = idle ? lsu_kind_t'(req_kind) : kind_q;
  assign a_f3   = idle ? req_funct3 : f3_q;
  assign a_lo   = idle ? req_addr[1:0] : addr_q[1:0];
  lsu_align u_align (
    .kind_i  (a_kind),
    .funct3_i(a_f3),
    .addr_i  (a_lo),
    .wdata_i (wdata_q),
    .rdata_i (dc_rdata),
    .err_o   (err),
    .be_o    (be),
    .wdata_o (fmt_wd),
    .rdata_o (ld)
  );
  assign req_ready      = idle;
  assign dc_valid       = state_q == S_MEM;
  assign dc_flash       = state_q == S_FLUSH_REQ;
  assign resp_valid     = state_q == S_RESP;
  assign resp_err       = resp_valid & err_q;
  assign resp_rd        = resp_valid ? rd_q : '0;
  assign resp_data      = resp_valid ? data_q : '0;
  assign dc_addr        = dc_valid ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign dc_wdata       = dc_valid ? fmt_wd : '0;
  assign dc_byte_enable = dc_valid ? be : '0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      kind_q  <= LOAD;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (req_valid) begin
          kind_q  <= a_kind;
          f3_q    <= req_funct3;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          rd_q    <= (a_kind == LOAD && !err) ? req_rd : '0;
          data_q  <= '0;
          err_q   <= err;
          state_q <= err ? S_RESP : a_kind == FENCE ? (FENCE_FLUSH ? S_FLUSH_REQ : S_RESP) : S_MEM;
        end
        S_MEM: if (dc_ready) begin
          if (kind_q == LOAD) data_q <= ld;
          state_q <= S_RESP;
        end
        S_FLUSH_REQ:  state_q <= S_FLUSH_WAIT;
        S_FLUSH_WAIT: if (dc_flash_done) state_q <= S_RESP;
        S_RESP:       state_q <= S_IDLE;
        default:      state_q <= S_IDLE;
      endcase
    end
  end
endmodule
